// File: rtl/fewcore_rf_pkg.sv
// Shared definitions for the fewcore multi-port register file.
//   rf_state_e : bank sequencer states (CLEAR zeroes storage, RUN serves traffic)
//   DEF_*      : datapath defaults shared with the rest of the core
//   bus_w()    : width of a packed bus carrying n fields of w bits
package fewcore_rf_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_AMOUNT     = 16;
    localparam int DEF_ADDRESSLEN = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    function automatic int bus_w(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/rf_read_mux.sv
// Per-read-port value selection for the register file.
//   addr   : read address of this port
//   waddr  : packed write addresses of all write ports
//   wdata  : packed write data of all write ports
//   wen    : write enables of all write ports
//   stored : storage contents at addr
//   value  : data this port should capture at the next edge
// Priority (highest first): hardwired zero, out-of-range, same-cycle write
// bypass (highest write port wins), storage.
module rf_read_mux
    import fewcore_rf_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int AMOUNT     = DEF_AMOUNT,
    parameter int ADDRESSLEN = DEF_ADDRESSLEN,
    parameter int NWRITE     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic [ADDRESSLEN-1:0]                addr,
    input  logic [bus_w(NWRITE, ADDRESSLEN)-1:0] waddr,
    input  logic [bus_w(NWRITE, XLEN)-1:0]       wdata,
    input  logic [NWRITE-1:0]                    wen,
    input  logic [XLEN-1:0]                      stored,
    output logic [XLEN-1:0]                      value
);

    always_comb begin
        value = stored;
        // Ascending scan so the highest matching write port is the last assignment.
        for (int j = 0; j < NWRITE; j++) begin
            if (wen[j] && waddr[j*ADDRESSLEN +: ADDRESSLEN] == addr)
                value = wdata[j*XLEN +: XLEN];
        end
        if (int'(addr) >= AMOUNT)
            value = '0;
        if (ZERO_REG != 0 && addr == '0)
            value = '0;
    end

endmodule

// File: rtl/banco_registrador_multi.sv
// Multi-port register file: NREAD registered read ports, NWRITE write ports,
// write-first bypass, optional hardwired r0, per-port read hold and a
// post-reset clearing pass that zeroes every register before ready rises.
//   clk    : clock, all state changes on posedge
//   reset  : synchronous active-high; restarts the clearing pass
//   raddr  : packed read addresses, port i at [i*ADDRESSLEN +: ADDRESSLEN]
//   ren    : per read port enable; 0 holds rdata
//   rdata  : packed registered read data, port i at [i*XLEN +: XLEN]
//   waddr  : packed write addresses
//   wdata  : packed write data
//   wen    : per write port enable
//   ready  : 1 once clearing is done and traffic is accepted
module banco_registrador_multi
    import fewcore_rf_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int AMOUNT     = DEF_AMOUNT,
    parameter int ADDRESSLEN = DEF_ADDRESSLEN,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [bus_w(NREAD, ADDRESSLEN)-1:0]  raddr,
    input  logic [NREAD-1:0]                     ren,
    output logic [bus_w(NREAD, XLEN)-1:0]        rdata,
    input  logic [bus_w(NWRITE, ADDRESSLEN)-1:0] waddr,
    input  logic [bus_w(NWRITE, XLEN)-1:0]       wdata,
    input  logic [NWRITE-1:0]                    wen,
    output logic                                 ready
);

    // Storage spans the full address space so an ADDRESSLEN-bit index is
    // always in range; entries at or above AMOUNT are never written and any
    // read of them is forced to zero by the read mux.
    localparam int                    MEMSZ = 2 ** ADDRESSLEN;
    localparam logic [ADDRESSLEN-1:0] LAST  = ADDRESSLEN'(AMOUNT - 1);

    rf_state_e                   state;
    logic [ADDRESSLEN-1:0]       clr_cnt;
    logic [XLEN-1:0]             mem [MEMSZ];
    logic [NREAD-1:0][XLEN-1:0]  rd_val;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [XLEN-1:0] stored;
        assign stored = mem[raddr[i*ADDRESSLEN +: ADDRESSLEN]];

        rf_read_mux #(
            .XLEN       (XLEN),
            .AMOUNT     (AMOUNT),
            .ADDRESSLEN (ADDRESSLEN),
            .NWRITE     (NWRITE),
            .ZERO_REG   (ZERO_REG)
        ) u_mux (
            .addr   (raddr[i*ADDRESSLEN +: ADDRESSLEN]),
            .waddr  (waddr),
            .wdata  (wdata),
            .wen    (wen),
            .stored (stored),
            .value  (rd_val[i])
        );
    end

    // Sequencer: clearing pass, ready flag and registered read ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    // Compare before increment so AMOUNT == 2^ADDRESSLEN
                    // finishes on the all-ones index without wrapping.
                    if (clr_cnt == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDRESSLEN'(1);
                    end
                end
                RUN: begin
                    for (int i = 0; i < NREAD; i++) begin
                        if (ren[i])
                            rdata[i*XLEN +: XLEN] <= rd_val[i];
                    end
                end
            endcase
        end
    end

    // Storage writes; kept free of reset so it maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                // Ascending loop: the highest write port to an address wins.
                for (int j = 0; j < NWRITE; j++) begin
                    if (wen[j]
                        && int'(waddr[j*ADDRESSLEN +: ADDRESSLEN]) < AMOUNT
                        && !(ZERO_REG != 0 && waddr[j*ADDRESSLEN +: ADDRESSLEN] == '0))
                        mem[waddr[j*ADDRESSLEN +: ADDRESSLEN]] <= wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: tb/tb_banco_registrador_multi.sv
module tb_banco_registrador_multi;

    localparam int XLEN = 32;
    localparam int AW   = 4;
    localparam int NR   = 2;
    localparam int NW   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR*AW-1:0]     raddr;
    logic [NR-1:0]        ren;
    logic [NR*XLEN-1:0]   rdata;
    logic [NW*AW-1:0]     waddr;
    logic [NW*XLEN-1:0]   wdata;
    logic [NW-1:0]        wen;
    logic                 ready;

    banco_registrador_multi #(
        .XLEN(XLEN), .AMOUNT(16), .ADDRESSLEN(AW),
        .NREAD(NR), .NWRITE(NW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .raddr(raddr), .ren(ren), .rdata(rdata),
        .waddr(waddr), .wdata(wdata), .wen(wen),
        .ready(ready)
    );

    always #5 clk = ~clk;

    // sel >= 0 : rdata port index, sel < 0 : ready flag
    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic expect_rd(input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.sel = sel; e.exp = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_ready(input logic v, input string tag);
        expect_rd(-1, {31'b0, v}, tag);
    endtask

    // Advance one edge, then compare every expectation queued for it.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel < 0) obs = {31'b0, ready};
            else           obs = rdata[e.sel*XLEN +: XLEN];
            total++;
            assert (obs === e.exp) passed++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
        raddr = {a1, a0};
        ren   = en;
    endtask

    task automatic set_wr(input logic [AW-1:0] a0, input logic [31:0] d0,
                          input logic [AW-1:0] a1, input logic [31:0] d1,
                          input logic [1:0] en);
        waddr = {a1, a0};
        wdata = {d1, d0};
        wen   = en;
    endtask

    initial begin
        reset = 1'b1;
        set_rd(4'd0, 4'd0, 2'b00);
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);

        // Reset state
        for (int k = 0; k < 2; k++) begin
            expect_ready(1'b0, "reset_ready");
            expect_rd(0, 32'h0, "reset_rdata0");
            expect_rd(1, 32'h0, "reset_rdata1");
            tick();
        end
        reset = 1'b0;

        // Clearing pass with traffic present: writes and reads must be ignored
        set_wr(4'd2, 32'hAA, 4'd2, 32'hAA, 2'b11);
        set_rd(4'd2, 4'd2, 2'b11);
        for (int k = 1; k <= 16; k++) begin
            expect_ready(k == 16, $sformatf("clear_ready_%0d", k));
            expect_rd(0, 32'h0, "clear_rdata0");
            expect_rd(1, 32'h0, "clear_rdata1");
            tick();
        end
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);

        // All registers read zero after clearing
        for (int a = 0; a < 8; a++) begin
            set_rd(AW'(a), AW'(a + 8), 2'b11);
            expect_rd(0, 32'h0, $sformatf("zero_r%0d", a));
            expect_rd(1, 32'h0, $sformatf("zero_r%0d", a + 8));
            tick();
        end

        // Same-cycle bypass, then from storage
        set_wr(4'd5, 32'hDEADBEEF, 4'd0, 32'h0, 2'b01);
        set_rd(4'd0, 4'd5, 2'b10);
        expect_rd(1, 32'hDEADBEEF, "bypass_r5");
        tick();
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);
        expect_rd(1, 32'hDEADBEEF, "stored_r5");
        tick();

        // Two write ports to one address: port 1 wins
        set_wr(4'd3, 32'h11, 4'd3, 32'h22, 2'b11);
        set_rd(4'd3, 4'd3, 2'b11);
        expect_rd(0, 32'h22, "wprio_bypass_p0");
        expect_rd(1, 32'h22, "wprio_bypass_p1");
        tick();
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);
        expect_rd(0, 32'h22, "wprio_stored_p0");
        expect_rd(1, 32'h22, "wprio_stored_p1");
        tick();

        // Hardwired r0
        set_wr(4'd0, 32'hFFFFFFFF, 4'd0, 32'hFFFFFFFF, 2'b11);
        set_rd(4'd0, 4'd0, 2'b11);
        expect_rd(0, 32'h0, "r0_bypass_p0");
        expect_rd(1, 32'h0, "r0_bypass_p1");
        tick();
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);
        expect_rd(0, 32'h0, "r0_stored_p0");
        expect_rd(1, 32'h0, "r0_stored_p1");
        tick();

        // Read hold on port 0
        set_wr(4'd7, 32'h1, 4'd0, 32'h0, 2'b01);
        set_rd(4'd0, 4'd0, 2'b00);
        tick();
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);
        set_rd(4'd7, 4'd0, 2'b01);
        expect_rd(0, 32'h1, "hold_initial");
        tick();
        set_wr(4'd7, 32'h2, 4'd0, 32'h0, 2'b01);
        set_rd(4'd7, 4'd0, 2'b00);
        expect_rd(0, 32'h1, "hold_during_write");
        tick();
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);
        expect_rd(0, 32'h1, "hold_after_write");
        tick();
        set_rd(4'd7, 4'd0, 2'b01);
        expect_rd(0, 32'h2, "hold_release");
        tick();

        // r9 written, then reset restarted mid-clear
        set_wr(4'd0, 32'h0, 4'd9, 32'h55, 2'b10);
        set_rd(4'd0, 4'd0, 2'b00);
        tick();
        set_wr(4'd0, 32'h0, 4'd0, 32'h0, 2'b00);
        set_rd(4'd9, 4'd9, 2'b11);
        expect_rd(0, 32'h55, "r9_before_reset");
        tick();
        set_rd(4'd0, 4'd0, 2'b00);
        reset = 1'b1;
        expect_ready(1'b0, "rst1_ready");
        expect_rd(0, 32'h0, "rst1_rdata0");
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            expect_ready(1'b0, "partial_clear_ready");
            tick();
        end
        reset = 1'b1;
        expect_ready(1'b0, "rst2_ready");
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            expect_ready(k == 16, $sformatf("reclear_ready_%0d", k));
            tick();
        end
        set_rd(4'd9, 4'd9, 2'b11);
        expect_rd(0, 32'h0, "r9_after_reclear_p0");
        expect_rd(1, 32'h0, "r9_after_reclear_p1");
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
